// File: rtl/lcd_reader.sv
// lcd_reader: reads the busy flag/address counter or a data byte from an HD44780 LCD,
//   optionally re-polling the busy flag until it clears or the poll limit is reached.
//   clk_i/rst_ni        clock, asynchronous active-low reset
//   clk_en_i            FSM, counters and outputs advance only when high
//   start_i, data_a_i   start an instruction in IDLE; data_a_i[0]=RS, [1]=poll (RS=0 only)
//   data_b_i            reserved
//   result_o, done_o    {timeout, 23'b0, byte}; done_o pulses for one enabled cycle
//   rs_o, rw_o, e_o     LCD RS, R/W (1 while the LCD drives the bus), E
//   data_bus_i          LCD DB7..DB0 as read back from the pads
module lcd_reader #(
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 25,
  parameter int HOLD_CYCLES  = 25,
  parameter int MAX_POLLS    = 50000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clk_en_i,
  input  logic        start_i,
  input  logic [31:0] data_a_i,
  input  logic [31:0] data_b_i,
  output logic [31:0] result_o,
  output logic        done_o,
  output logic        rs_o,
  output logic        rw_o,
  output logic        e_o,
  input  logic [7:0]  data_bus_i
);
  localparam logic [15:0] S_LAST = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] P_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] H_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] M_LAST = 16'(MAX_POLLS - 1);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;
  state_t      state_q;
  logic [15:0] cnt_q, polls_q;
  logic [7:0]  sample_q;
  logic        poll_q;
  logic        unused_ok;
  assign unused_ok = ^{data_b_i, data_a_i[31:2]};
  // A busy sample on the last allowed poll is the only way to finish with the timeout bit set.
  logic busy_d;
  assign busy_d = poll_q & sample_q[7];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      polls_q  <= '0;
      sample_q <= '0;
      poll_q   <= 1'b0;
      result_o <= '0;
      done_o   <= 1'b0;
      rs_o     <= 1'b0;
      rw_o     <= 1'b0;
      e_o      <= 1'b0;
    end else if (clk_en_i) begin
      case (state_q)
        IDLE: if (start_i) begin
          rs_o    <= data_a_i[0];
          poll_q  <= data_a_i[1] & ~data_a_i[0];
          polls_q <= '0;
          cnt_q   <= '0;
          rw_o    <= 1'b1;
          state_q <= SETUP;
        end
        SETUP: if (cnt_q == S_LAST) begin
          cnt_q   <= '0;
          e_o     <= 1'b1;
          state_q <= PULSE;
        end else cnt_q <= cnt_q + 16'd1;
        PULSE: if (cnt_q == P_LAST) begin
          sample_q <= data_bus_i;
          cnt_q    <= '0;
          e_o      <= 1'b0;
          state_q  <= HOLD;
        end else cnt_q <= cnt_q + 16'd1;
        HOLD: if (cnt_q == H_LAST) begin
          cnt_q <= '0;
          if (busy_d && polls_q != M_LAST) begin
            polls_q <= polls_q + 16'd1;
            state_q <= SETUP;
          end else begin
            result_o <= {busy_d, 23'b0, sample_q};
            done_o   <= 1'b1;
            rw_o     <= 1'b0;
            state_q  <= DONE;
          end
        end else cnt_q <= cnt_q + 16'd1;
        DONE: begin
          done_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
